sipo_deser: RTL and testbench

//  Serial-in/parallel-out deserializer; the receive stage downstream of the 4-bit PISO shifter.

---
 rtl/sipo_deser.sv | 131 +++++++++++++
 tb/tb_sipo_deser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: rebuilds WIDTH-bit words from a start-aligned bit stream.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit and report parity_err.
module sipo_deser #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sin,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

`ifdef PARITY_CHECK_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_n;
   logic [CW-1:0]    count, count_n;
   logic [WIDTH-1:0] sreg, sreg_n, shifted, data_n;
   logic             valid_n, ferr_n;
`ifdef PARITY_CHECK_EN
   logic             perr_n;
`endif

   // Ordering is fixed by the shift direction: whichever end the first bit enters, it ends opposite.
   always_comb begin
      if (MSB_FIRST)
         shifted = {sreg[WIDTH-2:0], sin};
      else
         shifted = {sin, sreg[WIDTH-1:1]};
   end

   // Next-state logic; the edge that captures the last data bit ignores start.
   always_comb begin
      state_n = state;
      count_n = count;
      sreg_n  = sreg;
      data_n  = data_out;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef PARITY_CHECK_EN
      perr_n  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               sreg_n  = shifted;
               count_n = ONE;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            sreg_n  = shifted;
            count_n = count + ONE;
            if (count == LAST) begin
`ifdef PARITY_CHECK_EN
               state_n = PARITY;
`else
               state_n = IDLE;
               count_n = '0;
               data_n  = shifted;
               valid_n = 1'b1;
`endif
            end else if (start) begin
               ferr_n  = 1'b1;
               count_n = ONE;
            end
         end
`ifdef PARITY_CHECK_EN
         PARITY: begin
            if (start) begin
               ferr_n  = 1'b1;
               sreg_n  = shifted;
               count_n = ONE;
               state_n = SHIFT;
            end else begin
               data_n  = sreg;
               valid_n = 1'b1;
               perr_n  = sin ^ (^sreg);
               count_n = '0;
               state_n = IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         sreg       <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         sreg       <= sreg_n;
         data_out   <= data_n;
         data_valid <= valid_n;
         busy       <= (state_n != IDLE);
         frame_err  <= ferr_n;
      end
   end

`ifdef PARITY_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)
         parity_err <= 1'b0;
      else
         parity_err <= perr_n;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser (WIDTH=4): directed vector table, back-to-back sequence and random run
// against a bit-queue reference model; both MSB_FIRST settings run side by side.
module tb_sipo_deser;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, sin = 1'b0;
   logic [W-1:0] dmsb, dlsb;
   logic vmsb, vlsb, bmsb, blsb, fmsb, flsb, pmsb, plsb;

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .sin(sin),
      .data_out(dmsb), .data_valid(vmsb), .busy(bmsb),
      .frame_err(fmsb), .parity_err(pmsb)
   );

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .start(start), .sin(sin),
      .data_out(dlsb), .data_valid(vlsb), .busy(blsb),
      .frame_err(flsb), .parity_err(plsb)
   );

   typedef struct {
      logic       r, s, d;
      logic       valid;
      logic [3:0] dm, dl;
      logic       busy, ferr;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // Reference model: collect the frame's bits in a queue and build the word arithmetically.
   bit         inFrame = 0;
   bit         bits[$];
   logic [3:0] mMsb = '0, mLsb = '0;
   bit         mValid = 0, mBusy = 0, mFerr = 0;

   function automatic vec_t mk(logic r, logic s, logic d, logic v, logic [3:0] dm,
                               logic [3:0] dl, logic b, logic f);
      vec_t t;
      t.r = r; t.s = s; t.d = d; t.valid = v; t.dm = dm; t.dl = dl; t.busy = b; t.ferr = f;
      return t;
   endfunction

   task automatic modelStep(input logic r, input logic s, input logic d);
      int accM, accL;
      mValid = 0;
      mFerr  = 0;
      if (r) begin
         inFrame = 0;
         bits.delete();
         mMsb = '0;
         mLsb = '0;
      end else if (!inFrame) begin
         if (s) begin
            inFrame = 1;
            bits.delete();
            bits.push_back(d);
         end
      end else if (s && bits.size() != W - 1) begin
         mFerr = 1;
         bits.delete();
         bits.push_back(d);
      end else begin
         bits.push_back(d);
         if (bits.size() == W) begin
            accM = 0;
            accL = 0;
            for (int i = 0; i < W; i++) begin
               accM = accM * 2 + int'(bits[i]);
               accL = accL + (int'(bits[i]) << i);
            end
            mMsb    = 4'(accM);
            mLsb    = 4'(accL);
            mValid  = 1;
            inFrame = 0;
            bits.delete();
         end
      end
      mBusy = inFrame;
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic d);
      rst   = r;
      start = s;
      sin   = d;
      @(posedge clk);
      #1;
      cycle++;
      modelStep(r, s, d);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cycle, act, exp);
      end
   endtask

   task automatic checkModel();
      checkOutput("rand data_out msb", 8'(dmsb), 8'(mMsb));
      checkOutput("rand data_out lsb", 8'(dlsb), 8'(mLsb));
      checkOutput("rand data_valid", {6'd0, vmsb, vlsb}, {6'd0, mValid, mValid});
      checkOutput("rand busy", {6'd0, bmsb, blsb}, {6'd0, mBusy, mBusy});
      checkOutput("rand frame_err", {6'd0, fmsb, flsb}, {6'd0, mFerr, mFerr});
      checkOutput("rand parity_err", {6'd0, pmsb, plsb}, 8'd0);
   endtask

   initial begin
      vec_t        vecs[$];
      logic [3:0]  words[2];
      int          pulseCycle[$];
      logic [3:0]  pulseData[$];
      logic        r, s, d;

      $display("[TB] sipo_deser bench start");

      // rst, start, sin -> valid, data msb-first, data lsb-first, busy, frame_err
      vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 4'h0, 4'h0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'h0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 4'hB, 4'hD, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 4'hB, 4'hD, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 4'hB, 4'hD, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'hB, 4'hD, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 4'hB, 4'hD, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 4'hB, 4'hD, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'hB, 4'hD, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 4'h3, 4'hC, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 4'h3, 4'hC, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 4'h3, 4'hC, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'h3, 4'hC, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 4'hA, 4'h5, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'hA, 4'h5, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 4'hA, 4'h5, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'hA, 4'h5, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'h0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 4'h6, 4'h6, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 4'h0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'h0, 0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].r, vecs[i].s, vecs[i].d);
         checkOutput($sformatf("vec%0d data_out msb", i), 8'(dmsb), 8'(vecs[i].dm));
         checkOutput($sformatf("vec%0d data_out lsb", i), 8'(dlsb), 8'(vecs[i].dl));
         checkOutput($sformatf("vec%0d data_valid", i), {6'd0, vmsb, vlsb},
                     {6'd0, vecs[i].valid, vecs[i].valid});
         checkOutput($sformatf("vec%0d busy", i), {6'd0, bmsb, blsb},
                     {6'd0, vecs[i].busy, vecs[i].busy});
         checkOutput($sformatf("vec%0d frame_err", i), {6'd0, fmsb, flsb},
                     {6'd0, vecs[i].ferr, vecs[i].ferr});
         checkOutput($sformatf("vec%0d parity_err", i), {6'd0, pmsb, plsb}, 8'd0);
      end

      // Back-to-back frames 0xA then 0x5 with no gap cycle.
      words[0] = 4'hA;
      words[1] = 4'h5;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < W; i++) begin
            applyStimulus(1'b0, i == 0, words[w][W-1-i]);
            if (vmsb) begin
               pulseCycle.push_back(cycle);
               pulseData.push_back(dmsb);
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (vmsb) begin
            pulseCycle.push_back(cycle);
            pulseData.push_back(dmsb);
         end
      end
      checkOutput("b2b pulse count", 8'(pulseCycle.size()), 8'd2);
      if (pulseCycle.size() == 2) begin
         checkOutput("b2b pulse spacing", 8'(pulseCycle[1] - pulseCycle[0]), 8'd4);
         checkOutput("b2b first word", 8'(pulseData[0]), 8'hA);
         checkOutput("b2b second word", 8'(pulseData[1]), 8'h5);
      end

      // Random traffic against the reference model.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkModel();
      for (int n = 0; n < 800; n++) begin
         r = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 4) == 0);
         d = 1'($urandom_range(0, 1));
         applyStimulus(r, s, d);
         checkModel();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
